// File: rtl/bram_pkg.sv
// Shared constants and types for the Wishbone BRAM read-modify-write bridge.
// Holds the read-latency modes and the RMW state encoding.
package bram_pkg;

    localparam int LOW_LATENCY      = 0;
    localparam int HIGH_PERFORMANCE = 1;

    typedef enum logic [1:0] {
        RMW_IDLE,
        RMW_RD,
        RMW_WAIT,
        RMW_WR
    } rmw_state_t;

    function automatic int read_latency(input int oreg);
        return (oreg == HIGH_PERFORMANCE) ? 2 : 1;
    endfunction

endpackage

// File: rtl/wb_byte_merge.sv
// Byte-lane merge for partial writes: selected bytes come from the new
// data, the rest from the word read back from the BRAM.
module wb_byte_merge #(
    parameter int DW    = 18,
    parameter int CFGDW = 32
) (
    input  logic [DW-1:0]         old_data,
    input  logic [DW-1:0]         new_data,
    input  logic [(DW+7)/8-1:0]   sel,
    output logic [DW-1:0]         merged
);

    localparam int NB = (DW + 7) / 8;

    // Each bit follows the enable of the byte lane it lives in.
    always_comb begin
        merged = old_data;
        for (int i = 0; i < DW; i++) begin
            if (sel[i/8]) merged[i] = new_data[i];
        end
    end

    logic unused_cfg;
    assign unused_cfg = (NB > CFGDW / 8);

endmodule

// File: rtl/wb_bram_rmw.sv
// Wishbone pipelined slave in front of a single-port BRAM; partial writes
// are turned into a read-modify-write sequence that stalls the bus.
module wb_bram_rmw
    import bram_pkg::*;
#(
    parameter int CFGAW       = 32,
    parameter int CFGDW       = 32,
    parameter int DW          = 18,
    parameter int DEPTH       = 1024,
    parameter int SIGN_EXTEND = 0,
    parameter int OREG        = HIGH_PERFORMANCE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cyc_i,
    input  logic                     stb_i,
    input  logic                     we_i,
    input  logic [CFGDW/8-1:0]       sel_i,
    input  logic [CFGAW-1:0]         addr_i,
    input  logic [CFGDW-1:0]         data_i,
    output logic [CFGDW-1:0]         data_o,
    output logic                     ack_o,
    output logic                     err_o,
    output logic                     stall_o,
    output logic                     bram_en,
    output logic                     bram_we,
    output logic [$clog2(DEPTH)-1:0] bram_addr,
    output logic [DW-1:0]            bram_dout,
    input  logic [DW-1:0]            bram_din,
    output logic                     bram_regce
);

    localparam int BRAMAW = $clog2(DEPTH);
    localparam int L      = read_latency(OREG);
    localparam int NB     = (DW + 7) / 8;
    localparam int CW     = 2;
    localparam logic [63:0] DEPTH_W = 64'(DEPTH);

    rmw_state_t        state, state_nx;
    logic [CW-1:0]     wait_cnt, wait_cnt_nx;
    logic [BRAMAW-1:0] rmw_addr;
    logic [DW-1:0]     rmw_data;
    logic [NB-1:0]     rmw_sel;
    logic              rmw_ack;
    logic [L-1:0]      pipe_vld;
    logic [L-1:0]      pipe_err;

    logic              accept;
    logic              in_range;
    logic              full_sel;
    logic              no_sel;
    logic              start_rmw;
    logic              push_vld;
    logic              resp_ok;
    logic [NB-1:0]     sel_dw;
    logic [DW-1:0]     merged;
    logic [CFGDW-1:0]  din_pad;

    // Only the byte lanes overlapping the BRAM word matter.
    assign sel_dw    = sel_i[NB-1:0];
    assign full_sel  = &sel_dw;
    assign no_sel    = ~|sel_dw;
    assign in_range  = 64'(addr_i) < DEPTH_W;

    assign stall_o   = (state != RMW_IDLE);
    assign accept    = cyc_i & stb_i & ~stall_o & ~rst;
    assign start_rmw = accept & we_i & in_range & ~full_sel & ~no_sel;
    assign push_vld  = accept & ~start_rmw;

    assign bram_regce = 1'b1;

    wb_byte_merge #(
        .DW    (DW),
        .CFGDW (CFGDW)
    ) u_merge (
        .old_data (bram_din),
        .new_data (rmw_data),
        .sel      (rmw_sel),
        .merged   (merged)
    );

    // RMW state and wait counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RMW_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
        end
    end

    // RMW sequencing; a dropped cycle abandons the sequence before the write.
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        unique case (state)
            RMW_IDLE: begin
                if (start_rmw) state_nx = RMW_RD;
            end
            RMW_RD: begin
                wait_cnt_nx = '0;
                if (!cyc_i)      state_nx = RMW_IDLE;
                else if (L == 1) state_nx = RMW_WR;
                else             state_nx = RMW_WAIT;
            end
            RMW_WAIT: begin
                if (!cyc_i) begin
                    state_nx    = RMW_IDLE;
                    wait_cnt_nx = '0;
                end else if (wait_cnt == CW'(L - 2)) begin
                    state_nx    = RMW_WR;
                    wait_cnt_nx = '0;
                end else begin
                    wait_cnt_nx = wait_cnt + 1'b1;
                end
            end
            RMW_WR: begin
                state_nx = RMW_IDLE;
            end
            default: begin
                state_nx = RMW_IDLE;
            end
        endcase
    end

    // BRAM port drive; nothing reaches the BRAM while reset is held.
    always_comb begin
        bram_en   = 1'b0;
        bram_we   = 1'b0;
        bram_addr = addr_i[BRAMAW-1:0];
        bram_dout = data_i[DW-1:0];
        if (!rst) begin
            unique case (state)
                RMW_IDLE: begin
                    if (accept && in_range && (!we_i || full_sel)) begin
                        bram_en = 1'b1;
                        bram_we = we_i;
                    end
                end
                RMW_RD: begin
                    bram_addr = rmw_addr;
                    bram_en   = cyc_i;
                end
                RMW_WAIT: begin
                    bram_addr = rmw_addr;
                end
                RMW_WR: begin
                    bram_en   = 1'b1;
                    bram_we   = 1'b1;
                    bram_addr = rmw_addr;
                    bram_dout = merged;
                end
                default: begin
                    bram_en = 1'b0;
                end
            endcase
        end
    end

    // Capture the partial write so the bus is free to change under the RMW.
    always_ff @(posedge clk) begin
        if (start_rmw) begin
            rmw_addr <= addr_i[BRAMAW-1:0];
            rmw_data <= data_i[DW-1:0];
            rmw_sel  <= sel_dw;
        end
    end

    // Response shift register of {valid, err}, flushed by reset or cyc drop.
    always_ff @(posedge clk) begin
        if (rst || !cyc_i) begin
            pipe_vld <= '0;
            pipe_err <= '0;
            rmw_ack  <= 1'b0;
        end else begin
            pipe_vld[0] <= push_vld;
            pipe_err[0] <= push_vld & ~in_range;
            for (int i = 1; i < L; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_err[i] <= pipe_err[i-1];
            end
            rmw_ack <= (state == RMW_WR);
        end
    end

    generate
        if (DW == CFGDW) begin : g_nopad
            assign din_pad = bram_din;
        end else if (SIGN_EXTEND != 0) begin : g_sext
            assign din_pad = {{(CFGDW-DW){bram_din[DW-1]}}, bram_din};
        end else begin : g_zext
            assign din_pad = {{(CFGDW-DW){1'b0}}, bram_din};
        end
    endgenerate

    assign resp_ok = pipe_vld[L-1] & ~pipe_err[L-1];
    assign ack_o   = resp_ok | rmw_ack;
    assign err_o   = pipe_vld[L-1] & pipe_err[L-1];
    assign data_o  = resp_ok ? din_pad : '0;

    logic unused_in;
    assign unused_in = ^{data_i, sel_i};

endmodule
